// File: rtl/drum_mac_if.sv
// drum_mac_if: handshake bundle between a beat source/sink and drum_mac.
// Latency: none (wires only).
// Backpressure: in_ready stalls the source; out_ready stalls the result stage.
interface drum_mac_if #(
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int ACC_W = N + M + 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [M-1:0]     in_b;
  logic             in_signed;
  logic             in_exact;
  logic             in_acc;
  logic             in_clr;
  logic             out_valid;
  logic             out_ready;
  logic [N+M-1:0]   out_prod;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;

  // Beat source / result sink side.
  modport master (
    output in_valid, in_a, in_b, in_signed, in_exact, in_acc, in_clr, out_ready,
    input  in_ready, out_valid, out_prod, out_acc, out_ovf
  );

  // MAC side.
  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_exact, in_acc, in_clr, out_ready,
    output in_ready, out_valid, out_prod, out_acc, out_ovf
  );
endinterface

// File: rtl/drum_mac.sv
// drum_mac: DRUM approximate / exact multiplier with sticky-overflow accumulator.
// Latency: 3 cycles (S1 leading-one/mantissa, S2 multiply, S3 shift/sign/accumulate).
// Backpressure: per-stage valid bits; a stage loads when empty or draining, so out_ready low fills the pipe and then drops in_ready.
module drum_mac #(
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int K     = 6,
  parameter int ACC_W = N + M + 8
) (
  input  logic       clk,
  input  logic       rst,
  drum_mac_if.slave  bus
);

  localparam int PW   = N + M;
  localparam int X_W  = (N > M) ? N : M;
  localparam int SH_W = $clog2(PW + 1);

  typedef struct packed {
    logic [N-1:0]    mag_a;
    logic [M-1:0]    mag_b;
    logic [K-1:0]    mant_a;
    logic [K-1:0]    mant_b;
    logic [SH_W-1:0] p_a;
    logic [SH_W-1:0] p_b;
    logic            neg;
    logic            sgn;
    logic            exact;
    logic            acc;
    logic            clr;
  } s1_t;

  typedef struct packed {
    logic [PW-1:0]   prod;
    logic [SH_W-1:0] sh;
    logic            neg;
    logic            sgn;
    logic            acc;
    logic            clr;
  } s2_t;

  // Shift = position of the leading one above the K-bit window, 0 if it fits.
  function automatic logic [SH_W-1:0] drum_shift(input logic [X_W-1:0] x);
    logic [SH_W-1:0] p;
    p = '0;
    for (int i = K; i < X_W; i++) begin
      if (x[i]) p = SH_W'(i - (K - 1));
    end
    return p;
  endfunction

  // Mantissa: K bits from the leading one down, LSB forced to 1 to unbias truncation.
  function automatic logic [K-1:0] drum_mant(input logic [X_W-1:0] x, input logic [SH_W-1:0] p);
    logic [K-1:0] m;
    if (p != '0) m = K'(x >> p) | K'(1);
    else         m = x[K-1:0];
    return m;
  endfunction

  logic             s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic s1_ld_en, s2_ld_en, s3_ld_en, s2_load, s3_load, in_ready, accept;

  // Stage enables: a stage loads when empty or when the stage below takes its beat.
  always_comb begin
    s3_ld_en = !s3_vld_q || bus.out_ready;
    s2_ld_en = !s2_vld_q || s3_ld_en;
    s1_ld_en = !s1_vld_q || s2_ld_en;
    in_ready = !rst && s1_ld_en;
    accept   = bus.in_valid && in_ready;
    s2_load  = s2_ld_en && s1_vld_q;
    s3_load  = s3_ld_en && s2_vld_q;
    s1_vld_d = s1_ld_en ? accept   : s1_vld_q;
    s2_vld_d = s2_ld_en ? s1_vld_q : s2_vld_q;
    s3_vld_d = s3_ld_en ? s2_vld_q : s3_vld_q;
  end

  logic [N-1:0] mag_a;
  logic [M-1:0] mag_b;

  // S1: ones'-complement magnitude, leading-one detect and mantissa selection.
  always_comb begin
    mag_a = (bus.in_signed && bus.in_a[N-1]) ? ~bus.in_a : bus.in_a;
    mag_b = (bus.in_signed && bus.in_b[M-1]) ? ~bus.in_b : bus.in_b;
    s1_d  = s1_q;
    if (accept) begin
      s1_d.mag_a  = mag_a;
      s1_d.mag_b  = mag_b;
      s1_d.p_a    = drum_shift(X_W'(mag_a));
      s1_d.p_b    = drum_shift(X_W'(mag_b));
      s1_d.mant_a = drum_mant(X_W'(mag_a), s1_d.p_a);
      s1_d.mant_b = drum_mant(X_W'(mag_b), s1_d.p_b);
      s1_d.neg    = bus.in_signed && (bus.in_a[N-1] ^ bus.in_b[M-1]);
      s1_d.sgn    = bus.in_signed;
      s1_d.exact  = bus.in_exact;
      s1_d.acc    = bus.in_acc;
      s1_d.clr    = bus.in_clr;
    end
  end

  // S2: multiply either full magnitudes or the two K-bit mantissas.
  always_comb begin
    s2_d = s2_q;
    if (s2_load) begin
      if (s1_q.exact) begin
        s2_d.prod = PW'(s1_q.mag_a) * PW'(s1_q.mag_b);
        s2_d.sh   = '0;
      end else begin
        s2_d.prod = PW'(s1_q.mant_a) * PW'(s1_q.mant_b);
        s2_d.sh   = s1_q.p_a + s1_q.p_b;
      end
      s2_d.neg = s1_q.neg;
      s2_d.sgn = s1_q.sgn;
      s2_d.acc = s1_q.acc;
      s2_d.clr = s1_q.clr;
    end
  end

  logic [PW-1:0]    shifted, prod_o;
  logic [ACC_W-1:0] addend, base;
  logic [ACC_W:0]   sum;
  logic             ovf_hit;

  // S3: scale, apply sign, and fold into the accumulator with overflow tracking.
  always_comb begin
    shifted = s2_q.prod << s2_q.sh;
    prod_o  = s2_q.neg ? ~shifted : shifted;
    addend  = ACC_W'(prod_o);
    if (s2_q.sgn && prod_o[PW-1]) addend = addend | ({ACC_W{1'b1}} << PW);
    base    = s2_q.clr ? '0 : acc_q;
    sum     = {1'b0, base} + {1'b0, addend};
    ovf_hit = s2_q.sgn ? ((base[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]))
                       : sum[ACC_W];
    prod_d  = prod_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (s3_load) begin
      prod_d = prod_o;
      if (s2_q.acc) begin
        acc_d = sum[ACC_W-1:0];
        ovf_d = (s2_q.clr ? 1'b0 : ovf_q) | ovf_hit;
      end else if (s2_q.clr) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end
    end
  end

  // State registers; reset drops every beat in flight and clears the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s3_vld_q <= s3_vld_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s3_vld_q;
  assign bus.out_prod  = prod_q;
  assign bus.out_acc   = acc_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_drum_mac.sv
// tb_drum_mac: scoreboard bench for drum_mac (ACC_W=24 unit and ACC_W=16 unit).
// Latency: expects 3 cycles from accepted input to out_valid.
// Backpressure: out_ready is dropped mid-burst; held outputs are checked for stability.
module tb_drum_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  drum_mac_if #(.N(8), .M(8), .ACC_W(24)) if0 ();
  drum_mac_if #(.N(8), .M(8), .ACC_W(16)) if1 ();

  drum_mac #(.N(8), .M(8), .K(6), .ACC_W(24)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  drum_mac #(.N(8), .M(8), .K(6), .ACC_W(16)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

  typedef struct {
    logic [15:0] prod;
    logic [23:0] acc;
    logic        ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit          hv[2];
  logic [15:0] hp[2];
  logic [23:0] ha[2];
  logic        ho[2];

  // Burst vectors: unsigned, accumulate, mode flips every few beats.
  logic [7:0]  ba   [10] = '{8'd200, 8'd200, 8'd255, 8'd255, 8'd0, 8'd100, 8'd100, 8'd64, 8'd1, 8'd13};
  logic [7:0]  bb   [10] = '{8'd3, 8'd3, 8'd255, 8'd255, 8'd77, 8'd100, 8'd100, 8'd64, 8'd1, 8'd11};
  logic        bx   [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [15:0] bp   [10] = '{16'd612, 16'd600, 16'd63504, 16'd65025, 16'd0,
                            16'd10404, 16'd10000, 16'd4356, 16'd1, 16'd143};
  logic [23:0] bacc [10] = '{24'd612, 24'd1212, 24'd64716, 24'd129741, 24'd129741,
                            24'd140145, 24'd150145, 24'd154501, 24'd154502, 24'd154645};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, expv);
    end
  endtask

  task automatic set_in(input int u, input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic sg, input logic ex, input logic ac, input logic cl);
    if (u == 0) begin
      if0.in_valid = v; if0.in_a = a; if0.in_b = b;
      if0.in_signed = sg; if0.in_exact = ex; if0.in_acc = ac; if0.in_clr = cl;
    end else begin
      if1.in_valid = v; if1.in_a = a; if1.in_b = b;
      if1.in_signed = sg; if1.in_exact = ex; if1.in_acc = ac; if1.in_clr = cl;
    end
  endtask

  task automatic idle(input int u);
    set_in(u, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Offer one beat, wait (bounded) for acceptance, then queue its expected result.
  task automatic send(input int u, input logic [7:0] a, input logic [7:0] b,
                      input logic sg, input logic ex, input logic ac, input logic cl,
                      input logic [15:0] ep, input logic [23:0] ea, input logic eo);
    logic rdy;
    int   n;
    exp_t e;
    set_in(u, 1'b1, a, b, sg, ex, ac, cl);
    n = 0;
    do begin
      @(negedge clk);
      rdy = (u == 0) ? if0.in_ready : if1.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: unit %0d beat not accepted within %0d cycles", u, n);
    end else begin
      e.prod = ep; e.acc = ea; e.ovf = eo;
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  // Wait (bounded) for both scoreboards to empty; ends just after a rising edge.
  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q0.size() + q1.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: outstanding=%0d required=0", q0.size() + q1.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compare each delivered beat to the scoreboard; check stall stability.
  task automatic mon(input int u);
    logic v, r, o;
    logic [15:0] p;
    logic [23:0] a;
    exp_t e;
    if (u == 0) begin
      v = if0.out_valid; r = if0.out_ready; p = if0.out_prod; a = if0.out_acc; o = if0.out_ovf;
    end else begin
      v = if1.out_valid; r = if1.out_ready; p = if1.out_prod; a = 24'(if1.out_acc); o = if1.out_ovf;
    end
    if (hv[u]) begin
      chk("stall_valid", 32'(v), 32'd1);
      chk("stall_prod", 32'(p), 32'(hp[u]));
      chk("stall_acc", 32'(a), 32'(ha[u]));
      chk("stall_ovf", 32'(o), 32'(ho[u]));
    end
    hv[u] = v && !r;
    hp[u] = p; ha[u] = a; ho[u] = o;
    if (v && r) begin
      if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out: unit %0d prod=%0d with nothing expected", u, p);
      end else begin
        e = (u == 0) ? q0.pop_front() : q1.pop_front();
        chk(u == 0 ? "prod_u0" : "prod_u1", 32'(p), 32'(e.prod));
        chk(u == 0 ? "acc_u0" : "acc_u1", 32'(a), 32'(e.acc));
        chk(u == 0 ? "ovf_u0" : "ovf_u1", 32'(o), 32'(e.ovf));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    int   lat;
    int   ghost;
    exp_t e;
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    idle(0);
    idle(1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
    chk("rst_in_ready", 32'(if0.in_ready), 32'd0);
    chk("rst_out_prod", 32'(if0.out_prod), 32'd0);
    chk("rst_out_acc", 32'(if0.out_acc), 32'd0);
    chk("rst_out_ovf", 32'(if0.out_ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst_u0", 32'(if0.in_ready), 32'd1);
    chk("ready_after_rst_u1", 32'(if1.in_ready), 32'd1);
    @(posedge clk); #1;

    // First beat: 200*3 DRUM -> 612, measured latency.
    e.prod = 16'd612; e.acc = 24'd0; e.ovf = 1'b0;
    q0.push_back(e);
    set_in(0, 1'b1, 8'd200, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    idle(0);
    lat = 1;
    while (!if0.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);

    send(0, 8'd200, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0, 16'd600, 24'd0, 1'b0);
    send(0, 8'd13, 8'd11, 1'b0, 1'b0, 1'b0, 1'b0, 16'd143, 24'd0, 1'b0);
    send(0, 8'd13, 8'd11, 1'b0, 1'b1, 1'b0, 1'b0, 16'd143, 24'd0, 1'b0);
    send(0, 8'hF3, 8'd11, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFF7B, 24'd0, 1'b0);
    send(0, 8'hF3, 8'd11, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFF7B, 24'd0, 1'b0);
    // Accumulate: 143 then signed 0xFF7B (-133) -> 10, then a clear-only beat.
    send(0, 8'd13, 8'd11, 1'b0, 1'b1, 1'b1, 1'b1, 16'd143, 24'd143, 1'b0);
    send(0, 8'hF3, 8'd11, 1'b1, 1'b1, 1'b1, 1'b0, 16'hFF7B, 24'd10, 1'b0);
    send(0, 8'd2, 8'd3, 1'b0, 1'b1, 1'b0, 1'b1, 16'd6, 24'd0, 1'b0);
    idle(0);
    drain();

    // Back-to-back burst with out_ready low for three cycles.
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(0, ba[i], bb[i], 1'b0, bx[i], 1'b1, (i == 0), bp[i], bacc[i], 1'b0);
        idle(0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 if0.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 if0.out_ready = 1'b1;
      end
    join
    drain();

    // 16-bit accumulator: unsigned carry sets sticky ovf, clear drops it.
    send(1, 8'd255, 8'd255, 1'b0, 1'b1, 1'b1, 1'b1, 16'd65025, 24'd65025, 1'b0);
    send(1, 8'd255, 8'd255, 1'b0, 1'b1, 1'b1, 1'b0, 16'd65025, 24'd64514, 1'b1);
    send(1, 8'd255, 8'd255, 1'b0, 1'b1, 1'b0, 1'b1, 16'd65025, 24'd0, 1'b0);
    send(1, 8'd255, 8'd255, 1'b0, 1'b1, 1'b1, 1'b0, 16'd65025, 24'd65025, 1'b0);
    send(1, 8'd255, 8'd255, 1'b0, 1'b1, 1'b1, 1'b0, 16'd65025, 24'd64514, 1'b1);
    idle(1);
    drain();

    // Reset with two beats in flight: neither may ever appear.
    set_in(0, 1'b1, 8'd13, 8'd11, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(0);
    @(negedge clk);
    chk("rst_in_ready_comb", 32'(if0.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst2_out_valid", 32'(if0.out_valid), 32'd0);
    chk("rst2_out_prod", 32'(if0.out_prod), 32'd0);
    chk("rst2_out_acc", 32'(if0.out_acc), 32'd0);
    chk("rst2_u1_acc", 32'(if1.out_acc), 32'd0);
    chk("rst2_u1_ovf", 32'(if1.out_ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst2", 32'(if0.in_ready), 32'd1);
    ghost = 0;
    repeat (8) begin
      @(negedge clk);
      if (if0.out_valid) ghost++;
    end
    chk("no_ghost_beats", 32'(ghost), 32'd0);

    @(posedge clk); #1;
    send(0, 8'd13, 8'd11, 1'b0, 1'b1, 1'b0, 1'b0, 16'd143, 24'd0, 1'b0);
    idle(0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
